alu16: RTL and testbench

- 16-bit registered arithmetic/logic unit. Operands A and B and a 3-bit opcode are accepted on an input-valid strobe; the result and status flags are registered.
- Outputs appear one clock later. Sits in the datapath between the register-file read ports and the writeback/branch logic.
- Zero flag drives branch-equal decisions.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu16_core.sv | 53 +++++
 rtl/alu16.sv | 61 ++++++
 tb/tb_alu16.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the 16-bit registered ALU.
//   WIDTH    - operand/result width (only 16 is supported)
//   OP_*     - 3-bit opcode encodings
//   flags_t  - status flag bundle {zero, carry, overflow, negative}
package alu_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu16_core.sv
// alu16_core: combinational 16-bit ALU datapath.
// Ports:
//   A, B     in  [15:0] operands (B[3:0] is the shift amount for SLL/SRL)
//   control  in  [2:0]  opcode
//   result   out [15:0] operation result
//   flags    out        {zero, carry, overflow, negative} derived from result
module alu16_core
    import alu_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  control,
    output logic [15:0] result,
    output flags_t      flags
);

    logic [16:0] sum;
    logic [16:0] diff;

    // 17-bit forms: bit 16 of the sum is carry-out, bit 16 of the
    // difference is set exactly when A < B unsigned (borrow).
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result         = '0;
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        unique case (control)
            OP_ADD: begin
                result         = sum[15:0];
                flags.carry    = sum[16];
                flags.overflow = (A[15] == B[15]) && (sum[15] != A[15]);
            end
            OP_SUB: begin
                result         = diff[15:0];
                flags.carry    = diff[16];
                flags.overflow = (A[15] != B[15]) && (diff[15] != A[15]);
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_SLT: result = ($signed(A) < $signed(B)) ? 16'h0001 : 16'h0000;
            OP_SLL: result = A << B[3:0];
            OP_SRL: result = A >> B[3:0];
            default: result = '0;
        endcase
        // Zero/Negative come from the result about to be registered.
        flags.zero     = ~|result;
        flags.negative = result[15];
    end

endmodule

// File: rtl/alu16.sv
// alu16: registered 16-bit ALU, one-cycle latency, no backpressure.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           A/B/control valid this cycle
//   A, B, control      operands and opcode
//   Out                registered result
//   Zero, Carry,
//   Overflow, Negative registered status flags
//   out_valid          Out/flags were loaded at the most recent edge
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             out_valid
);

    import alu_pkg::*;

    logic [15:0] result;
    flags_t      flags;

    alu16_core u_core (
        .A       (A),
        .B       (B),
        .control (control),
        .result  (result),
        .flags   (flags)
    );

    // Zero resets high so the flags agree with the reset Out of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            Zero      <= 1'b1;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out      <= result;
                Zero     <= flags.zero;
                Carry    <= flags.carry;
                Overflow <= flags.overflow;
                Negative <= flags.negative;
            end
        end
    end

endmodule

// File: tb/tb_alu16.sv
module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  control;
    logic [15:0] Out;
    logic        Zero;
    logic        Carry;
    logic        Overflow;
    logic        Negative;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;
    logic [15:0] prev_out;

    alu16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .control   (control),
        .Out       (Out),
        .Zero      (Zero),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Negative  (Negative),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_z,
                           input logic e_c, input logic e_v, input logic e_n, input logic e_vld);
        chk({tag, ".Out"}, Out, e_out);
        chk({tag, ".Zero"}, {15'd0, Zero}, {15'd0, e_z});
        chk({tag, ".Carry"}, {15'd0, Carry}, {15'd0, e_c});
        chk({tag, ".Overflow"}, {15'd0, Overflow}, {15'd0, e_v});
        chk({tag, ".Negative"}, {15'd0, Negative}, {15'd0, e_n});
        chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, e_vld});
    endtask

    // Drive on the falling edge, confirm Out has not yet moved, then check
    // everything just after the next rising edge.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] e_out, input logic e_z,
                         input logic e_c, input logic e_v, input logic e_n);
        @(negedge clk);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        control  = op;
        #1;
        chk({tag, ".pre_edge"}, Out, prev_out);
        @(posedge clk);
        #1;
        chk_all(tag, e_out, e_z, e_c, e_v, e_n, 1'b1);
        prev_out = e_out;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        control  = 3'b000;
        prev_out = 16'h0000;
        #12;
        chk_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vectors: tag, A, B, op, Out, Z, C, V, N
        do_op("add_1_2",    16'h0001, 16'h0002, 3'b000, 16'h0003, 0, 0, 0, 0);
        do_op("sub_4_2",    16'h0004, 16'h0002, 3'b001, 16'h0002, 0, 0, 0, 0);
        do_op("sub_1_2",    16'h0001, 16'h0002, 3'b001, 16'hFFFF, 0, 1, 0, 1);
        do_op("and_logic",  16'hF333, 16'h0CCC, 3'b010, 16'h0000, 1, 0, 0, 0);
        do_op("or_logic",   16'hF333, 16'h0CCC, 3'b011, 16'hFFFF, 0, 0, 0, 1);
        do_op("xor_logic",  16'hF333, 16'h0CCC, 3'b100, 16'hFFFF, 0, 0, 0, 1);
        do_op("xor_zero",   16'h0000, 16'h0000, 3'b100, 16'h0000, 1, 0, 0, 0);
        do_op("slt_eq",     16'h0001, 16'h0001, 3'b101, 16'h0000, 1, 0, 0, 0);
        do_op("slt_neg",    16'hFFFF, 16'h0001, 3'b101, 16'h0001, 0, 0, 0, 0);
        do_op("slt_min",    16'h8000, 16'h7FFF, 3'b101, 16'h0001, 0, 0, 0, 0);
        do_op("slt_max",    16'h7FFF, 16'h8000, 3'b101, 16'h0000, 1, 0, 0, 0);
        do_op("sll_0",      16'h0001, 16'h0000, 3'b110, 16'h0001, 0, 0, 0, 0);
        do_op("srl_0",      16'h0001, 16'h0000, 3'b111, 16'h0001, 0, 0, 0, 0);
        do_op("sll_15",     16'h0001, 16'h000F, 3'b110, 16'h8000, 0, 0, 0, 1);
        do_op("srl_b13",    16'h8000, 16'h0013, 3'b111, 16'h1000, 0, 0, 0, 0);
        do_op("sll_bhi",    16'h00FF, 16'hFFF4, 3'b110, 16'h0FF0, 0, 0, 0, 0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 3'b000, 16'h8000, 0, 0, 1, 1);
        do_op("add_wrap",   16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1, 1, 0, 0);
        do_op("and_clr_c",  16'h00F0, 16'h0FF0, 3'b010, 16'h00F0, 0, 0, 0, 0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 3'b001, 16'h7FFF, 0, 0, 1, 0);
        do_op("sub_eq",     16'h1234, 16'h1234, 3'b001, 16'h0000, 1, 0, 0, 0);
        do_op("add_negovf", 16'h8000, 16'h8000, 3'b000, 16'h0000, 1, 1, 1, 0);

        // Hold: in_valid low for two cycles with changing operands.
        @(negedge clk);
        in_valid = 1'b0;
        A        = 16'h1111;
        B        = 16'h2222;
        control  = 3'b000;
        @(posedge clk);
        #1;
        chk_all("hold1", 16'h0000, 1, 1, 1, 0, 0);
        @(negedge clk);
        A = 16'h7FFF;
        control = 3'b011;
        @(posedge clk);
        #1;
        chk_all("hold2", 16'h0000, 1, 1, 1, 0, 0);

        do_op("after_hold", 16'h0005, 16'h0003, 3'b001, 16'h0002, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a valid operation.
        do_op("pre_rst",    16'h8000, 16'h0000, 3'b011, 16'h8000, 0, 0, 0, 1);
        @(negedge clk);
        A       = 16'h0001;
        B       = 16'h0001;
        control = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 16'h0000, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        prev_out = 16'h0000;
        do_op("post_rst",   16'h0010, 16'h0001, 3'b111, 16'h0008, 0, 0, 0, 0);

        @(negedge clk);
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
